// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types, sizes and the circular first-set-bit search for the
// round-robin decode arbiter.
package rr_decode_arbiter_pkg;

    localparam int unsigned NUM_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Result of a circular search: found flag plus the winning index.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req, searching upward from start and wrapping 15 -> 0.
    // The request vector is doubled and shifted so the search becomes a
    // plain lowest-set-bit scan; the offset is added back modulo 16 by the
    // natural wrap of the IDX_W-bit sum.
    function automatic pick_t rr_first_set(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   start
    );
        logic [2*NUM_REQ-1:0] dbl;
        logic [2*NUM_REQ-1:0] rot;
        logic [IDX_W-1:0]     off;
        pick_t                res;
        dbl       = {req, req};
        rot       = dbl >> start;
        off       = '0;
        res.found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                res.found = 1'b1;
                off       = IDX_W'(i);
            end
        end
        res.idx = start + off;
        return res;
    endfunction

endpackage

// File: rtl/four_to_sixteen_decoder.sv
// Enabled 4-to-16 one-hot decoder.
// Ports:
//   a  - binary index
//   en - decode enable; output is all zeros when low
//   b  - one-hot result, b = en ? (1 << a) : 0
module four_to_sixteen_decoder (
    input  logic [3:0]  a,
    input  logic        en,
    output logic [15:0] b
);

    always_comb begin
        b = 16'h0000;
        if (en) begin
            b[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_priority_pick.sv
// Combinational circular priority pick over the 16 request lines.
// Ports:
//   req   - request vector
//   start - index where the circular search begins (highest priority)
//   found - at least one request bit is set
//   idx   - index of the first set bit at or after start, wrapping 15 -> 0
module rr_priority_pick
    import rr_decode_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    pick_t pick;

    always_comb begin
        pick  = rr_first_set(req, start);
        found = pick.found;
        idx   = pick.idx;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one resource among 16 requesters, with a
// per-grant hold limit so no requester can monopolise the resource.
// Ports:
//   clk          - rising-edge clock
//   rst_n        - synchronous active-low reset
//   arb_en       - arbiter enable; when low no grant is issued or held
//   req          - level requests, one bit per requester
//   grant_valid  - a grant is active this cycle (registered)
//   grant_idx    - granted requester index, valid with grant_valid (registered)
//   grant_onehot - decode of grant_idx/grant_valid (combinational)
//   hold_expired - one-cycle pulse after a grant is cut at MAX_HOLD (registered)
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic               hold_expired
);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [IDX_W-1:0] pick_start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             hold_max;
    logic             release_grant;

    // In IDLE the search starts at the stored pointer; while granting it
    // starts just past the current owner so a release can regrant in the
    // same cycle, wrapping back to the owner if it is the only requester.
    always_comb begin
        pick_start    = (state == ST_GRANT) ? (grant_idx + IDX_W'(1)) : ptr;
        hold_max      = (hold_cnt == CNT_W'(MAX_HOLD));
        release_grant = !req[grant_idx] || hold_max || !arb_en;
    end

    rr_priority_pick u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            hold_expired <= 1'b0;
        end else begin
            hold_expired <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_en && pick_found) begin
                        state       <= ST_GRANT;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= CNT_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (!release_grant) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end else begin
                        hold_expired <= hold_max;
                        ptr          <= grant_idx + IDX_W'(1);
                        if (arb_en && pick_found) begin
                            grant_idx <= pick_idx;
                            hold_cnt  <= CNT_W'(1);
                        end else begin
                            state       <= ST_IDLE;
                            grant_valid <= 1'b0;
                            hold_cnt    <= '0;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    four_to_sixteen_decoder u_dec (
        .a  (grant_idx),
        .en (grant_valid),
        .b  (grant_onehot)
    );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=2)
// share one stimulus stream; a vector table and directed sequences check
// known scenarios, then random traffic is compared with a reference model.
module tb_rr_decode_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en;
    logic [15:0] req;

    logic        a_valid, b_valid;
    logic [3:0]  a_idx, b_idx;
    logic [15:0] a_onehot, b_onehot;
    logic        a_expired, b_expired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_decode_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_en       (arb_en),
        .req          (req),
        .grant_valid  (a_valid),
        .grant_idx    (a_idx),
        .grant_onehot (a_onehot),
        .hold_expired (a_expired)
    );

    rr_decode_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_en       (arb_en),
        .req          (req),
        .grant_valid  (b_valid),
        .grant_idx    (b_idx),
        .grant_onehot (b_onehot),
        .hold_expired (b_expired)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one entry per instance, plain integers.
    int mh[2]      = '{8, 2};
    bit m_valid[2] = '{1'b0, 1'b0};
    int m_idx[2]   = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int m_ptr[2]   = '{0, 0};
    bit m_exp[2]   = '{1'b0, 1'b0};

    function automatic int rr_search(input logic [15:0] r, input int start);
        for (int k = 0; k < 16; k++) begin
            if (r[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_valid[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0; m_exp[i] = 0;
            end else if (!m_valid[i]) begin
                m_exp[i] = 0;
                if (arb_en && req != 16'h0) begin
                    m_idx[i] = rr_search(req, m_ptr[i]);
                    m_valid[i] = 1;
                    m_cnt[i] = 1;
                end
            end else if (req[m_idx[i]] && m_cnt[i] != mh[i] && arb_en) begin
                m_exp[i] = 0;
                m_cnt[i]++;
            end else begin
                m_exp[i] = (m_cnt[i] == mh[i]);
                m_ptr[i] = (m_idx[i] + 1) % 16;
                if (arb_en && req != 16'h0) begin
                    m_idx[i] = rr_search(req, m_ptr[i]);
                    m_cnt[i] = 1;
                end else begin
                    m_valid[i] = 0;
                    m_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [15:0] q);
        rst_n  = r;
        arb_en = e;
        req    = q;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic check_model();
        logic [15:0] exp_oh;
        exp_oh = m_valid[0] ? (16'h1 << m_idx[0]) : 16'h0;
        check("m8_valid", 16'(a_valid), 16'(m_valid[0]));
        if (m_valid[0]) check("m8_idx", 16'(a_idx), 16'(m_idx[0]));
        check("m8_onehot", a_onehot, exp_oh);
        check("m8_expired", 16'(a_expired), 16'(m_exp[0]));
        exp_oh = m_valid[1] ? (16'h1 << m_idx[1]) : 16'h0;
        check("m2_valid", 16'(b_valid), 16'(m_valid[1]));
        if (m_valid[1]) check("m2_idx", 16'(b_idx), 16'(m_idx[1]));
        check("m2_onehot", b_onehot, exp_oh);
        check("m2_expired", 16'(b_expired), 16'(m_exp[1]));
    endtask

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] req;
        logic        valid;
        logic [3:0]  idx;
        logic        expired;
    } vec_t;

    vec_t vecs[18];
    int   rr_idx[8] = '{0, 0, 8, 8, 15, 15, 0, 0};
    bit   rr_exp[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [15:0] exp_oh;
        logic [15:0] cur_req;
        logic        r, e;

        // Table for the MAX_HOLD=8 instance: reset, single request,
        // disable/re-enable, early release, idle return, reset mid-grant.
        vecs[0]  = '{1'b0, 1'b0, 16'h0200, 1'b0, 4'd0,  1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0200, 1'b0, 4'd0,  1'b0};
        vecs[2]  = '{1'b1, 1'b1, 16'h0200, 1'b1, 4'd9,  1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'h0200, 1'b1, 4'd9,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0200, 1'b0, 4'd0,  1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'h0020, 1'b1, 4'd5,  1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'h0020, 1'b1, 4'd5,  1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'hFFFF, 1'b0, 4'd0,  1'b0};
        vecs[8]  = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd6,  1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 4'd3,  1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'h0018, 1'b1, 4'd3,  1'b0};
        vecs[11] = '{1'b1, 1'b1, 16'h0018, 1'b1, 4'd3,  1'b0};
        vecs[12] = '{1'b1, 1'b1, 16'h0010, 1'b1, 4'd4,  1'b0};
        vecs[13] = '{1'b1, 1'b1, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[14] = '{1'b1, 1'b1, 16'h1000, 1'b1, 4'd12, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 16'h1000, 1'b1, 4'd12, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 4'd0,  1'b0};
        vecs[17] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd0,  1'b0};

        for (int v = 0; v < 18; v++) begin
            cycle(vecs[v].rst_n, vecs[v].en, vecs[v].req);
            exp_oh = vecs[v].valid ? (16'h1 << vecs[v].idx) : 16'h0;
            check($sformatf("vec%0d_valid", v), 16'(a_valid), 16'(vecs[v].valid));
            if (vecs[v].valid || !vecs[v].rst_n)
                check($sformatf("vec%0d_idx", v), 16'(a_idx), 16'(vecs[v].idx));
            check($sformatf("vec%0d_onehot", v), a_onehot, exp_oh);
            check($sformatf("vec%0d_expired", v), 16'(a_expired), 16'(vecs[v].expired));
        end

        // Round-robin with MAX_HOLD=2: 0, 8, 15, 0, two cycles each.
        cycle(1'b0, 1'b0, 16'h0000);
        for (int n = 0; n < 8; n++) begin
            cycle(1'b1, 1'b1, 16'h8101);
            check($sformatf("rr%0d_valid", n), 16'(b_valid), 16'h1);
            check($sformatf("rr%0d_idx", n), 16'(b_idx), 16'(rr_idx[n]));
            check($sformatf("rr%0d_expired", n), 16'(b_expired), 16'(rr_exp[n]));
        end

        // Sole requester with MAX_HOLD=8: regranted, pulse every 8 cycles.
        cycle(1'b0, 1'b0, 16'h0000);
        for (int n = 1; n <= 30; n++) begin
            cycle(1'b1, 1'b1, 16'h0040);
            check($sformatf("sole%0d_valid", n), 16'(a_valid), 16'h1);
            check($sformatf("sole%0d_idx", n), 16'(a_idx), 16'd6);
            check($sformatf("sole%0d_expired", n), 16'(a_expired),
                  16'((n > 1) && (n % 8 == 1)));
        end

        // Random traffic against the reference model.
        cur_req = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(63) != 0);
            e = ($urandom_range(11) != 0);
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0:       cur_req = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    1:       cur_req = 16'h1 << $urandom_range(15);
                    2:       cur_req = 16'($urandom);
                    default: cur_req = 16'h0;
                endcase
            end
            cycle(r, e, cur_req);
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
